// File: rtl/alu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// alu_pipe_ctrl : single-issue ALU, 1-cycle ops plus WIDTH-cycle shift-add MUL
// Revision 1.0
// ============================================================================
module alu_pipe_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [3:0]       alu_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_SUB  = 4'b0010;
  localparam logic [3:0] c_OP_AND  = 4'b0011;
  localparam logic [3:0] c_OP_OR   = 4'b0100;
  localparam logic [3:0] c_OP_XOR  = 4'b0101;
  localparam logic [3:0] c_OP_SLL  = 4'b0110;
  localparam logic [3:0] c_OP_SRL  = 4'b0111;
  localparam logic [3:0] c_OP_SLT  = 4'b1000;
  localparam logic [3:0] c_OP_SLTU = 4'b1001;
  localparam logic [3:0] c_OP_MUL  = 4'b1010;

  localparam logic [SHW-1:0] c_LAST_BIT = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             overflow_q;
  logic             out_valid_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;

  logic             accept_d;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic [SHW-1:0]   shamt_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_carry_d;
  logic             alu_ovf_d;
  logic [WIDTH-1:0] acc_d;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept_d  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

  // Single-cycle operations evaluated directly from the presented operands.
  always_comb begin
    sum_d       = {1'b0, operand1} + {1'b0, operand2};
    diff_d      = {1'b0, operand1} - {1'b0, operand2};
    shamt_d     = operand2[SHW-1:0];
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    alu_ovf_d   = 1'b0;
    case (alu_opcode)
      c_OP_ADD: begin
        alu_res_d   = sum_d[WIDTH-1:0];
        alu_carry_d = sum_d[WIDTH];
        alu_ovf_d   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                      (sum_d[WIDTH-1] != operand1[WIDTH-1]);
      end
      c_OP_SUB: begin
        // The extra MSB of the widened difference is the unsigned borrow.
        alu_res_d   = diff_d[WIDTH-1:0];
        alu_carry_d = diff_d[WIDTH];
        alu_ovf_d   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                      (diff_d[WIDTH-1] != operand1[WIDTH-1]);
      end
      c_OP_AND:  alu_res_d = operand1 & operand2;
      c_OP_OR:   alu_res_d = operand1 | operand2;
      c_OP_XOR:  alu_res_d = operand1 ^ operand2;
      c_OP_SLL:  alu_res_d = operand1 << shamt_d;
      c_OP_SRL:  alu_res_d = operand1 >> shamt_d;
      c_OP_SLT:  alu_res_d[0] = $signed(operand1) < $signed(operand2);
      c_OP_SLTU: alu_res_d[0] = operand1 < operand2;
      default:   alu_res_d = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            if (alu_opcode == c_OP_MUL) begin
              mcand_q  <= operand1;
              mplier_q <= operand2;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else begin
              result_q    <= alu_res_d;
              zero_q      <= (alu_res_d == '0);
              carry_q     <= alu_carry_d;
              overflow_q  <= alu_ovf_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle; the last bit lands straight in result.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == c_LAST_BIT) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_pipe_ctrl : vector table, corner sequences and randomized ops vs model
// Revision 1.0
// ============================================================================
module tb_alu_pipe_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic [3:0]   alu_opcode = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  alu_pipe_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand1   (operand1),
    .operand2   (operand2),
    .alu_opcode (alu_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    int           lat;
  } vec_t;

  vec_t tv[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the opcode definitions, using wide/signed arithmetic.
  task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic z, output logic c,
                        output logic v, output int lat);
    longint       sa, sb, ss;
    logic [63:0]  wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; lat = 1;
    case (op)
      4'h1: begin
        wide = {32'h0, a} + {32'h0, b};
        r = wide[31:0]; c = wide[32];
        ss = sa + sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'h2: begin
        r = a - b; c = (a < b);
        ss = sa - sb;
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = a << (b % 32);
      4'h7: r = a >> (b % 32);
      4'h8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h9: r = (a < b) ? 32'd1 : 32'd0;
      4'hA: begin
        wide = {32'h0, a} * {32'h0, b};
        r = wide[31:0];
        lat = W + 1;
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endtask

  // Present one op, scramble inputs after accept, wait for out_valid, hold, then handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] r, output logic z, output logic c,
                        output logic v, output int lat);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    alu_opcode = op; operand1 = a; operand2 = b;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    operand1 = $urandom; operand2 = $urandom; alu_opcode = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, "_in_ready_busy"}, in_ready, 0);
      step();
      lat++;
    end
    check({tag, "_out_valid_seen"}, out_valid, 1);
    r = result; z = zero; c = carry; v = overflow;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_result"}, result, r);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] r, er, a, b;
    logic         z, c, v, ez, ec, ev;
    logic [3:0]   op;
    int           lat, elat, seen;

    tv[0]  = '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    tv[1]  = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
    tv[2]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    tv[3]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    tv[4]  = '{4'hA, 32'd12345,    32'd678,      32'h007FB6F6, 1'b0, 1'b0, 1'b0, 33};
    tv[5]  = '{4'h7, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0, 1};
    tv[6]  = '{4'h0, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    tv[7]  = '{4'h6, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 1};
    tv[8]  = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
    tv[9]  = '{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
    tv[10] = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1};
    tv[11] = '{4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1};
    tv[12] = '{4'h7, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0, 1};
    tv[13] = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    tv[14] = '{4'h2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};

    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_carry", carry, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, 0, r, z, c, v, lat);
      check($sformatf("vec%0d_result", i), r, tv[i].res);
      check($sformatf("vec%0d_zero", i), z, tv[i].z);
      check($sformatf("vec%0d_carry", i), c, tv[i].c);
      check($sformatf("vec%0d_overflow", i), v, tv[i].v);
      check($sformatf("vec%0d_latency", i), lat, tv[i].lat);
    end

    // MUL result held while consumer stalls for 5 cycles
    run_op("mul_hold", 4'hA, 32'd1000, 32'd3000, 5, r, z, c, v, lat);
    check("mul_hold_result", r, 32'd3000000);
    check("mul_hold_latency", lat, 33);

    // Reset in the middle of a MUL aborts it
    alu_opcode = 4'hA; operand1 = 32'd12345; operand2 = 32'd678; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", seen, 0);
    run_op("post_abort_add", 4'h1, 32'd3, 32'd4, 0, r, z, c, v, lat);
    check("post_abort_add_result", r, 32'd7);
    check("post_abort_add_latency", lat, 1);

    // Randomized ops against the reference model
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        default: a = 32'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'h7FFFFFFF;
        2: b = 32'h00000001;
        default: b = 32'($urandom_range(0, 40));
      endcase
      ref_op(op, a, b, er, ez, ec, ev, elat);
      run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2), r, z, c, v, lat);
      check($sformatf("rnd%0d_op%0h_result", n, op), r, er);
      check($sformatf("rnd%0d_op%0h_zero", n, op), z, ez);
      check($sformatf("rnd%0d_op%0h_carry", n, op), c, ec);
      check($sformatf("rnd%0d_op%0h_overflow", n, op), v, ev);
      check($sformatf("rnd%0d_op%0h_latency", n, op), lat, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe_ctrl.md
ALU_PIPE_CTRL -- requirements
Module: alu_pipe_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are powers of two, 4 or greater.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived from WIDTH, never overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  an operation is presented on operand1/operand2/alu_opcode.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 operand1  input  WIDTH  first operand.
REQ-008 operand2  input  WIDTH  second operand; low SHW bits are the shift amount for shifts.
REQ-009 alu_opcode  input  4  operation select.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 carry  output  1  ADD carry-out / SUB borrow.
REQ-015 overflow  output  1  signed overflow on ADD/SUB.

Function
REQ-016 Opcodes: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL (logical), 1000 SLT (signed, result 1/0), 1001 SLTU (unsigned, result 1/0), 1010 MUL (low WIDTH bits of unsigned product); all other opcodes give result 0.
REQ-017 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE and rst low.
REQ-018 Accept = in_valid && in_ready at a rising edge; operands and opcode are captured at that edge, and later input changes have no effect on the accepted operation.
REQ-019 Non-MUL accepted in IDLE: result/flags registered at the accept edge, IDLE -> DONE; out_valid high the following cycle (latency 1).
REQ-020 MUL accepted in IDLE: IDLE -> MUL; shift-add iteration, one multiplier bit per cycle, counter 0..WIDTH-1.
REQ-021 MUL -> DONE on the edge processing bit WIDTH-1; out_valid high exactly WIDTH+1 cycles after the accept edge.
REQ-022 DONE: out_valid = 1; result and flags held stable until out_valid && out_ready; at that edge DONE -> IDLE and out_valid drops.
REQ-023 No new accept in MUL or DONE (in_ready = 0); minimum spacing between accepts is 2 cycles.
REQ-024 Shifts use operand2[SHW-1:0] only; upper bits ignored; shift by 0 returns operand1.
REQ-025 ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = operands of equal sign and result sign differs.
REQ-026 SUB: carry = 1 when operand1 < operand2 (unsigned); overflow = operands of differing sign and result sign differs from operand1.
REQ-027 carry = overflow = 0 for all opcodes other than ADD/SUB.
REQ-028 zero = (result == 0) for every opcode, including undefined opcodes (zero = 1).
REQ-029 Outputs change only at rising edges; no combinational path from inputs to result or flags.

Reset
REQ-030 With rst high at an edge: state -> IDLE; result, zero, carry, overflow, out_valid, and the MUL counter/accumulator -> 0.
REQ-031 in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst is low.
REQ-032 rst during MUL or DONE aborts the operation; no out_valid is produced for it.
REQ-033 rst has priority over accept and over out_ready at the same edge.

Verification (WIDTH=32)
REQ-034 Bench covers: ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, zero 1, carry 1, overflow 0, out_valid one cycle after accept.
REQ-035 Bench covers: SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1, carry 0; then SLT 0xFFFFFFFF, 0x00000001 -> 1; then SLTU with the same operands -> 0.
REQ-036 Bench covers: MUL 12345 * 678 -> result 8369910 (0x007FB6F6), out_valid exactly 33 cycles after accept, in_ready 0 throughout.
REQ-037 Bench covers: MUL result with out_ready held low 5 cycles -> result stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-038 Bench covers: SRL 0x80000000 by operand2 0x00000021 -> result 0x40000000 (shift by 1).
REQ-039 Bench covers: rst at cycle 10 of MUL -> no out_valid; first ADD 3 + 4 after release -> result 7. Separately, opcode 0000 -> result 0, zero 1.
